// File: rtl/pcm_frame_buffer.sv
// PCM frame buffer: packs interleaved channel writes into frames,
// queues them in a FIFO and serves one frame per consumer request.
module pcm_frame_buffer #(
  parameter int SAMPLE_WIDTH = 20,
  parameter int NUM_CHANNELS = 2,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 16,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int FW = NUM_CHANNELS * SAMPLE_WIDTH,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_val,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  output logic                    wr_full,
  output logic [CW-1:0]           wr_chan,
  input  logic                    wr_resync,
  input  logic                    mono_mode,
  input  logic                    rd_req,
  output logic                    rd_valid,
  output logic [FW-1:0]           rd_data,
  output logic                    rd_underrun,
  input  logic                    underrun_mode,
  output logic [LW-1:0]           level,
  output logic [CNT_WIDTH-1:0]    underrun_count,
  input  logic                    cnt_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = SAMPLE_WIDTH;

  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [FW-1:0] stage_q;
  logic [FW-1:0] last_q;
  logic [FW-1:0] push_frame;
  logic [LW-1:0] level_nxt;
  logic          accept;
  logic          last_slot;
  logic          push;
  logic          pop;
  logic          miss;

  assign accept    = wr_val && !wr_full && !wr_resync;
  assign last_slot = wr_chan == CW'(NUM_CHANNELS - 1);
  assign push      = accept && (mono_mode || last_slot);
  assign pop       = rd_req && (level != '0);
  assign miss      = rd_req && (level == '0);
  assign level_nxt = level + LW'(push) - LW'(pop);

  // Staging with the incoming sample dropped into its slot
  always_comb begin
    push_frame = stage_q;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (mono_mode || wr_chan == CW'(k))
        push_frame[k*SW +: SW] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_chan <= '0;
      stage_q <= '0;
    end else if (wr_resync) begin
      wr_chan <= '0;
      stage_q <= '0;
    end else if (accept && !mono_mode) begin
      stage_q <= push_frame;
      wr_chan <= last_slot ? '0 : wr_chan + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      wr_full <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      level   <= level_nxt;
      wr_full <= level_nxt == LW'(DEPTH);
    end
  end

  // Underrun replays the last delivered frame or silence
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_underrun <= 1'b0;
      last_q      <= '0;
    end else begin
      rd_valid <= rd_req;
      if (pop) begin
        rd_data     <= mem[rd_ptr];
        last_q      <= mem[rd_ptr];
        rd_underrun <= 1'b0;
      end else if (miss) begin
        rd_data     <= underrun_mode ? '0 : last_q;
        rd_underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      underrun_count <= '0;
    else if (cnt_clr)
      underrun_count <= miss ? CNT_WIDTH'(1) : '0;
    else if (miss && underrun_count != '1)
      underrun_count <= underrun_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Bench for pcm_frame_buffer: directed scenarios plus a random
// run checked against a queue-based reference model.
module tb_pcm_frame_buffer;

  localparam int SW    = 20;
  localparam int NC    = 2;
  localparam int DEPTH = 8;
  localparam int CNTW  = 2;
  localparam int CMAX  = 3;
  localparam int FW    = NC * SW;
  localparam int LW    = 4;

  typedef logic [FW-1:0] frame_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_val;
  logic [SW-1:0]   wr_data;
  logic            wr_full;
  logic            wr_chan;
  logic            wr_resync;
  logic            mono_mode;
  logic            rd_req;
  logic            rd_valid;
  logic [FW-1:0]   rd_data;
  logic            rd_underrun;
  logic            underrun_mode;
  logic [LW-1:0]   level;
  logic [CNTW-1:0] underrun_count;
  logic            cnt_clr;

  always #5 clk = ~clk;

  pcm_frame_buffer #(
    .SAMPLE_WIDTH(SW),
    .NUM_CHANNELS(NC),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_val(wr_val),
    .wr_data(wr_data),
    .wr_full(wr_full),
    .wr_chan(wr_chan),
    .wr_resync(wr_resync),
    .mono_mode(mono_mode),
    .rd_req(rd_req),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_underrun(rd_underrun),
    .underrun_mode(underrun_mode),
    .level(level),
    .underrun_count(underrun_count),
    .cnt_clr(cnt_clr)
  );

  int passed = 0;
  int total  = 0;

  frame_t        q[$];
  int            m_chan;
  logic [SW-1:0] m_stage[NC];
  frame_t        m_last;
  frame_t        e_data;
  logic          e_valid;
  logic          e_und;
  int            m_cnt;

  function automatic frame_t mk(int a, int b);
    return {SW'(b), SW'(a)};
  endfunction

  task automatic clr_in();
    wr_val    = 1'b0;
    wr_data   = '0;
    wr_resync = 1'b0;
    mono_mode = 1'b0;
    rd_req    = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  // Advance the model by one cycle from the current inputs, then clock.
  task automatic step();
    frame_t f;
    bit was_full;
    bit empty;
    if (rst) begin
      q.delete();
      m_chan  = 0;
      foreach (m_stage[i]) m_stage[i] = '0;
      m_last  = '0;
      e_data  = '0;
      e_valid = 1'b0;
      e_und   = 1'b0;
      m_cnt   = 0;
    end else begin
      was_full = q.size() == DEPTH;
      empty    = q.size() == 0;
      e_valid  = rd_req;
      if (rd_req && !empty) begin
        f      = q.pop_front();
        e_data = f;
        m_last = f;
        e_und  = 1'b0;
      end else if (rd_req) begin
        e_und  = 1'b1;
        e_data = underrun_mode ? '0 : m_last;
      end
      if (cnt_clr)
        m_cnt = (rd_req && empty) ? 1 : 0;
      else if (rd_req && empty && m_cnt < CMAX)
        m_cnt++;
      if (wr_resync) begin
        m_chan = 0;
        foreach (m_stage[i]) m_stage[i] = '0;
      end else if (wr_val && !was_full) begin
        if (mono_mode) begin
          q.push_back({wr_data, wr_data});
        end else begin
          m_stage[m_chan] = wr_data;
          if (m_chan == NC - 1) begin
            q.push_back({m_stage[1], m_stage[0]});
            m_chan = 0;
          end else begin
            m_chan++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(int v);
    clr_in();
    wr_val  = 1'b1;
    wr_data = SW'(v);
    step();
  endtask

  task automatic rd();
    clr_in();
    rd_req = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clr_in();
    underrun_mode = 1'b0;
    rst = 1'b1;
    step();
    step();
    total++; if (rd_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", rd_valid); else passed++;
    total++; if (rd_data !== '0) $display("FAIL rst_data got %h want 0", rd_data); else passed++;
    total++; if (rd_underrun !== 1'b0) $display("FAIL rst_und got %b want 0", rd_underrun); else passed++;
    total++; if (level !== 4'd0) $display("FAIL rst_level got %0d want 0", level); else passed++;
    total++; if (wr_full !== 1'b0) $display("FAIL rst_full got %b want 0", wr_full); else passed++;
    total++; if (wr_chan !== 1'b0) $display("FAIL rst_chan got %b want 0", wr_chan); else passed++;
    total++; if (underrun_count !== 2'd0) $display("FAIL rst_cnt got %0d want 0", underrun_count); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_stereo_order();
    int s = 0;
    int nrx = 0;
    logic prev_req;
    do_reset();
    for (int c = 0; c < 240; c++) begin
      clr_in();
      if (c % 2 == 0 && s < 100) begin
        wr_val  = 1'b1;
        wr_data = SW'(s - 50);
        s++;
      end
      rd_req   = (c % 4 == 0);
      prev_req = rd_req;
      step();
      total++; if (rd_valid !== prev_req) $display("FAIL order_latency c=%0d got %b want %b", c, rd_valid, prev_req); else passed++;
      if (rd_valid === 1'b1 && rd_underrun === 1'b0) begin
        total++;
        if (rd_data !== mk(-50 + 2*nrx, -49 + 2*nrx))
          $display("FAIL order_data n=%0d got %h want %h", nrx, rd_data, mk(-50 + 2*nrx, -49 + 2*nrx));
        else passed++;
        nrx++;
      end
    end
    total++; if (nrx != 50) $display("FAIL order_count got %0d want 50", nrx); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr(i);
      if (i == 14) begin
        total++; if (wr_full !== 1'b0) $display("FAIL full_early got %b want 0", wr_full); else passed++;
      end
      if (i == 15) begin
        total++; if (wr_full !== 1'b1) $display("FAIL full_flag got %b want 1", wr_full); else passed++;
        total++; if (level !== 4'd8) $display("FAIL full_level got %0d want 8", level); else passed++;
      end
    end
    total++; if (level !== 4'd8) $display("FAIL full_drop_level got %0d want 8", level); else passed++;
    total++; if (wr_chan !== 1'b0) $display("FAIL full_drop_chan got %b want 0", wr_chan); else passed++;
    for (int k = 0; k < 8; k++) begin
      rd();
      total++; if (rd_data !== mk(2*k, 2*k + 1)) $display("FAIL full_read k=%0d got %h want %h", k, rd_data, mk(2*k, 2*k + 1)); else passed++;
      total++; if (rd_underrun !== 1'b0) $display("FAIL full_read_und k=%0d got %b want 0", k, rd_underrun); else passed++;
      if (k == 0) begin
        total++; if (wr_full !== 1'b0) $display("FAIL full_deassert got %b want 0", wr_full); else passed++;
        total++; if (level !== 4'd7) $display("FAIL full_level7 got %0d want 7", level); else passed++;
      end
      clr_in();
      step();
    end
    total++; if (level !== 4'd0) $display("FAIL full_drained got %0d want 0", level); else passed++;
  endtask

  task automatic test_underrun();
    do_reset();
    underrun_mode = 1'b0;
    wr(50);
    wr(50);
    rd();
    total++; if (rd_data !== mk(50, 50) || rd_underrun !== 1'b0) $display("FAIL und_first got %h/%b want %h/0", rd_data, rd_underrun, mk(50, 50)); else passed++;
    for (int i = 0; i < 2; i++) begin
      clr_in();
      step();
      rd();
      total++; if (rd_data !== mk(50, 50) || rd_underrun !== 1'b1) $display("FAIL und_hold i=%0d got %h/%b want %h/1", i, rd_data, rd_underrun, mk(50, 50)); else passed++;
    end
    total++; if (underrun_count !== 2'd2) $display("FAIL und_cnt2 got %0d want 2", underrun_count); else passed++;
    underrun_mode = 1'b1;
    rd();
    total++; if (rd_data !== '0 || rd_underrun !== 1'b1) $display("FAIL und_zero got %h/%b want 0/1", rd_data, rd_underrun); else passed++;
    total++; if (underrun_count !== 2'd3) $display("FAIL und_cnt3 got %0d want 3", underrun_count); else passed++;
    underrun_mode = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    wr(11);
    clr_in();
    wr_val  = 1'b1;
    wr_data = SW'(12);
    rd_req  = 1'b1;
    step();
    total++; if (rd_valid !== 1'b1 || rd_underrun !== 1'b1) $display("FAIL sc_empty_und got %b/%b want 1/1", rd_valid, rd_underrun); else passed++;
    total++; if (level !== 4'd1) $display("FAIL sc_empty_level got %0d want 1", level); else passed++;
    wr(21); wr(22); wr(31); wr(32);
    total++; if (level !== 4'd3) $display("FAIL sc_level3 got %0d want 3", level); else passed++;
    wr(41);
    clr_in();
    wr_val  = 1'b1;
    wr_data = SW'(42);
    rd_req  = 1'b1;
    step();
    total++; if (level !== 4'd3) $display("FAIL sc_pushpop_level got %0d want 3", level); else passed++;
    total++; if (rd_data !== mk(11, 12) || rd_underrun !== 1'b0) $display("FAIL sc_pushpop_data got %h/%b want %h/0", rd_data, rd_underrun, mk(11, 12)); else passed++;
    rd();
    total++; if (rd_data !== mk(21, 22)) $display("FAIL sc_order1 got %h want %h", rd_data, mk(21, 22)); else passed++;
    rd();
    total++; if (rd_data !== mk(31, 32)) $display("FAIL sc_order2 got %h want %h", rd_data, mk(31, 32)); else passed++;
    rd();
    total++; if (rd_data !== mk(41, 42)) $display("FAIL sc_order3 got %h want %h", rd_data, mk(41, 42)); else passed++;
    total++; if (level !== 4'd0) $display("FAIL sc_drained got %0d want 0", level); else passed++;
  endtask

  task automatic test_mono_resync();
    do_reset();
    clr_in();
    mono_mode = 1'b1;
    wr_val    = 1'b1;
    wr_data   = SW'(7);
    step();
    total++; if (level !== 4'd1 || wr_chan !== 1'b0) $display("FAIL mono_push got %0d/%b want 1/0", level, wr_chan); else passed++;
    wr(1);
    total++; if (wr_chan !== 1'b1) $display("FAIL mono_partial got %b want 1", wr_chan); else passed++;
    clr_in();
    wr_resync = 1'b1;
    wr_val    = 1'b1;
    wr_data   = SW'(99);
    step();
    total++; if (wr_chan !== 1'b0 || level !== 4'd1) $display("FAIL resync got %b/%0d want 0/1", wr_chan, level); else passed++;
    wr(2);
    wr(3);
    total++; if (level !== 4'd2) $display("FAIL resync_level got %0d want 2", level); else passed++;
    rd();
    total++; if (rd_data !== mk(7, 7)) $display("FAIL mono_frame got %h want %h", rd_data, mk(7, 7)); else passed++;
    rd();
    total++; if (rd_data !== mk(2, 3)) $display("FAIL resync_frame got %h want %h", rd_data, mk(2, 3)); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) rd();
    total++; if (underrun_count !== 2'd3) $display("FAIL sat_cnt got %0d want 3", underrun_count); else passed++;
    clr_in();
    cnt_clr = 1'b1;
    rd_req  = 1'b1;
    step();
    total++; if (underrun_count !== 2'd1) $display("FAIL clr_und got %0d want 1", underrun_count); else passed++;
    wr(8); wr(9); wr(10); wr(11);
    rd();
    total++; if (rd_data !== mk(8, 9)) $display("FAIL sat_pop got %h want %h", rd_data, mk(8, 9)); else passed++;
    wr(5);
    total++; if (wr_chan !== 1'b1 || level !== 4'd1) $display("FAIL pre_rst got %b/%0d want 1/1", wr_chan, level); else passed++;
    clr_in();
    rd_req = 1'b1;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    total++; if (rd_valid !== 1'b0 || rd_data !== '0 || rd_underrun !== 1'b0) $display("FAIL mid_rst_rd got %b/%h/%b want 0/0/0", rd_valid, rd_data, rd_underrun); else passed++;
    total++; if (level !== 4'd0 || wr_full !== 1'b0 || wr_chan !== 1'b0 || underrun_count !== 2'd0) $display("FAIL mid_rst_state got %0d/%b/%b/%0d want 0/0/0/0", level, wr_full, wr_chan, underrun_count); else passed++;
    wr(6);
    wr(7);
    rd();
    total++; if (rd_data !== mk(6, 7)) $display("FAIL post_rst_frame got %h want %h", rd_data, mk(6, 7)); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      wr_val        = ($urandom_range(0, 9) < 6);
      wr_data       = SW'($urandom);
      wr_resync     = ($urandom_range(0, 99) < 3);
      mono_mode     = ($urandom_range(0, 9) == 0);
      rd_req        = ($urandom_range(0, 9) < 4);
      underrun_mode = 1'($urandom);
      cnt_clr       = ($urandom_range(0, 99) < 5);
      step();
      total++; if (rd_valid !== e_valid) $display("FAIL rnd_valid c=%0d got %b want %b", c, rd_valid, e_valid); else passed++;
      total++; if (rd_data !== e_data) $display("FAIL rnd_data c=%0d got %h want %h", c, rd_data, e_data); else passed++;
      total++; if (rd_underrun !== e_und) $display("FAIL rnd_und c=%0d got %b want %b", c, rd_underrun, e_und); else passed++;
      total++; if (level !== LW'(q.size())) $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, q.size()); else passed++;
      total++; if (wr_full !== (q.size() == DEPTH)) $display("FAIL rnd_full c=%0d got %b want %b", c, wr_full, q.size() == DEPTH); else passed++;
      total++; if (wr_chan !== 1'(m_chan)) $display("FAIL rnd_chan c=%0d got %b want %0d", c, wr_chan, m_chan); else passed++;
      total++; if (underrun_count !== CNTW'(m_cnt)) $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, underrun_count, m_cnt); else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    underrun_mode = 1'b0;
    clr_in();
    test_reset();
    test_stereo_order();
    test_full();
    test_underrun();
    test_same_cycle();
    test_mono_resync();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
